// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
package regfile_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned N_REQ = 4;

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter: first valid requester at or after PTR wins.
module rr_arb4
    import regfile_ctrl_pkg::*;
(
    input  logic [N_REQ-1:0] REQ,
    input  logic [1:0]       PTR,
    input  logic             EN,
    output logic [N_REQ-1:0] GNT,
    output logic [1:0]       GIDX
);

    logic       found;
    logic [1:0] idx;

    // Scan PTR, PTR+1, ... with 2-bit wrap; grant the first valid one.
    always_comb begin
        GNT   = '0;
        GIDX  = '0;
        found = 1'b0;
        idx   = '0;
        if (EN) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                idx = PTR + 2'(i);
                if (!found && REQ[idx]) begin
                    found    = 1'b1;
                    GNT[idx] = 1'b1;
                    GIDX     = idx;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Write-port controller: init sweep after reset / on request, then
// round-robin sharing of the single register-file write port.
module regfile_wr_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned           addr_width = 5,
    parameter int unsigned           data_width = 32,
    parameter int unsigned           lo         = 0,
    parameter int unsigned           hi         = 31,
    parameter logic [data_width-1:0] init_val   = '0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          INIT_REQ,
    input  logic [N_REQ-1:0]              REQ_VAL,
    input  logic [N_REQ*addr_width-1:0]   REQ_ADDR,
    input  logic [N_REQ*data_width-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]              REQ_RDY,
    output logic                          WR_EN,
    output logic [addr_width-1:0]         WR_ADDR,
    output logic [data_width-1:0]         WR_DATA,
    output logic                          INIT_DONE
);

    localparam logic [addr_width-1:0] LO_A = addr_width'(lo);
    localparam logic [addr_width-1:0] HI_A = addr_width'(hi);

    state_e                  state_q, state_d;
    logic [addr_width-1:0]   cnt_q, cnt_d;
    logic [1:0]              ptr_q, ptr_d;
    logic                    wr_en_q, wr_en_d;
    logic [addr_width-1:0]   wr_addr_q, wr_addr_d;
    logic [data_width-1:0]   wr_data_q, wr_data_d;
    logic                    init_done_q, init_done_d;

    logic                    arb_en;
    logic [N_REQ-1:0]        gnt;
    logic [1:0]              gidx;
    logic                    xfer;
    logic [addr_width-1:0]   req_addr_sel;
    logic [data_width-1:0]   req_data_sel;

    // INIT_REQ masks the arbiter so a colliding request is never granted.
    assign arb_en = (state_q == ST_RUN) && !INIT_REQ;

    rr_arb4 u_arb (
        .REQ  (REQ_VAL),
        .PTR  (ptr_q),
        .EN   (arb_en),
        .GNT  (gnt),
        .GIDX (gidx)
    );

    assign xfer         = |(gnt & REQ_VAL);
    assign req_addr_sel = REQ_ADDR[int'(gidx)*addr_width +: addr_width];
    assign req_data_sel = REQ_DATA[int'(gidx)*data_width +: data_width];

    // Next-state and next-output logic for the INIT/RUN controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        init_done_d = init_done_q;
        unique case (state_q)
            ST_INIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = init_val;
                if (INIT_REQ) begin
                    cnt_d = LO_A;
                end else if (cnt_q == HI_A) begin
                    // Terminate on equality so hi at the top of the address space never wraps.
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (INIT_REQ) begin
                    state_d     = ST_INIT;
                    cnt_d       = LO_A;
                    init_done_d = 1'b0;
                end else if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = req_addr_sel;
                    wr_data_d = req_data_sel;
                    ptr_d     = gidx + 2'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = LO_A;
            end
        endcase
    end

    // State and registered write-port outputs; asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_INIT;
            cnt_q       <= LO_A;
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            init_done_q <= init_done_d;
        end
    end

    assign REQ_RDY   = gnt;
    assign WR_EN     = wr_en_q;
    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign INIT_DONE = init_done_q;

`ifndef SYNTHESIS
    // Out-of-range writes are still forwarded; flag them for debugging only.
    always_ff @(posedge CLK) begin
        if (!RST && !INIT_REQ && xfer &&
            (int'(req_addr_sel) < int'(lo) || int'(req_addr_sel) > int'(hi)))
            $warning("regfile_wr_ctrl: write to out-of-range address %0d", req_addr_sel);
    end
`endif

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed bench for regfile_wr_ctrl: default 32-entry instance plus an
// 8-entry instance exercising the full address range of a 3-bit counter.
module tb_regfile_wr_ctrl;

    logic         clk;
    logic         rst;
    logic         init_req;
    logic [3:0]   req_val;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_rdy;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         init_done;

    logic         s_init_req;
    logic [3:0]   s_req_val;
    logic [11:0]  s_req_addr;
    logic [63:0]  s_req_data;
    logic [3:0]   s_req_rdy;
    logic         s_wr_en;
    logic [2:0]   s_wr_addr;
    logic [15:0]  s_wr_data;
    logic         s_init_done;

    int n_pass;
    int n_total;

    regfile_wr_ctrl u_dut (
        .CLK       (clk),
        .RST       (rst),
        .INIT_REQ  (init_req),
        .REQ_VAL   (req_val),
        .REQ_ADDR  (req_addr),
        .REQ_DATA  (req_data),
        .REQ_RDY   (req_rdy),
        .WR_EN     (wr_en),
        .WR_ADDR   (wr_addr),
        .WR_DATA   (wr_data),
        .INIT_DONE (init_done)
    );

    regfile_wr_ctrl #(
        .addr_width (3),
        .data_width (16),
        .lo         (0),
        .hi         (7),
        .init_val   (16'h5A5A)
    ) u_small (
        .CLK       (clk),
        .RST       (rst),
        .INIT_REQ  (s_init_req),
        .REQ_VAL   (s_req_val),
        .REQ_ADDR  (s_req_addr),
        .REQ_DATA  (s_req_data),
        .REQ_RDY   (s_req_rdy),
        .WR_EN     (s_wr_en),
        .WR_ADDR   (s_wr_addr),
        .WR_DATA   (s_wr_data),
        .INIT_DONE (s_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        req_val = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b exp 0", wr_en); else n_pass++;
        n_total++; if (wr_addr !== 5'd0) $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); else n_pass++;
        n_total++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data got %h exp 0", wr_data); else n_pass++;
        n_total++; if (init_done !== 1'b0) $display("FAIL reset_init_done got %b exp 0", init_done); else n_pass++;
        n_total++; if (req_rdy !== 4'b0000) $display("FAIL reset_req_rdy got %b exp 0000", req_rdy); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            n_total++;
            if (wr_en !== 1'b1 || wr_addr !== 5'(k) || wr_data !== 32'h0)
                $display("FAIL sweep_write k=%0d got en=%b addr=%0d data=%h exp en=1 addr=%0d data=0", k, wr_en, wr_addr, wr_data, k);
            else n_pass++;
            n_total++;
            if (init_done !== (k == 31))
                $display("FAIL sweep_init_done k=%0d got %b exp %b", k, init_done, (k == 31));
            else n_pass++;
            n_total++;
            if (req_rdy !== ((k == 31) ? 4'b0001 : 4'b0000))
                $display("FAIL sweep_req_rdy k=%0d got %b exp %b", k, req_rdy, ((k == 31) ? 4'b0001 : 4'b0000));
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        int g;
        for (int j = 0; j < 8; j++) begin
            g = j % 4;
            exp_rdy = 4'b0001 << ((j + 1) % 4);
            @(posedge clk); #1;
            n_total++;
            if (wr_en !== 1'b1 || wr_addr !== 5'(10 + g) || wr_data !== 32'(32'hA0 + g))
                $display("FAIL rr_write j=%0d got en=%b addr=%0d data=%h exp en=1 addr=%0d data=%h", j, wr_en, wr_addr, wr_data, 10 + g, 32'hA0 + g);
            else n_pass++;
            n_total++;
            if (req_rdy !== exp_rdy)
                $display("FAIL rr_grant j=%0d got %b exp %b", j, req_rdy, exp_rdy);
            else n_pass++;
        end
        req_val = 4'b0000;
        @(posedge clk); #1;
        n_total++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd13 || wr_data !== 32'hA3)
            $display("FAIL rr_idle_hold got en=%b addr=%0d data=%h exp en=0 addr=13 data=a3", wr_en, wr_addr, wr_data);
        else n_pass++;
    endtask

    task automatic test_sparse();
        // ptr is 0 here; one transfer from requester 1 moves it to 2
        req_val = 4'b0010; #1;
        n_total++; if (req_rdy !== 4'b0010) $display("FAIL sparse_setup_rdy got %b exp 0010", req_rdy); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (wr_addr !== 5'd11) $display("FAIL sparse_setup_addr got %0d exp 11", wr_addr); else n_pass++;
        req_val = 4'b0011; #1;
        n_total++; if (req_rdy !== 4'b0001) $display("FAIL sparse_grant0 got %b exp 0001", req_rdy); else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd10 || wr_data !== 32'hA0)
            $display("FAIL sparse_write0 got en=%b addr=%0d data=%h exp en=1 addr=10 data=a0", wr_en, wr_addr, wr_data);
        else n_pass++;
        req_val = 4'b0010; #1;
        n_total++; if (req_rdy !== 4'b0010) $display("FAIL sparse_grant1 got %b exp 0010", req_rdy); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (wr_addr !== 5'd11 || wr_data !== 32'hA1) $display("FAIL sparse_write1 got addr=%0d data=%h exp addr=11 data=a1", wr_addr, wr_data); else n_pass++;
        req_val = 4'b1001; #1;
        n_total++; if (req_rdy !== 4'b1000) $display("FAIL sparse_grant3_before0 got %b exp 1000", req_rdy); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (wr_addr !== 5'd13 || wr_data !== 32'hA3) $display("FAIL sparse_write3 got addr=%0d data=%h exp addr=13 data=a3", wr_addr, wr_data); else n_pass++;
        req_val = 4'b0001; #1;
        n_total++; if (req_rdy !== 4'b0001) $display("FAIL sparse_grant0_after3 got %b exp 0001", req_rdy); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (wr_addr !== 5'd10) $display("FAIL sparse_write0b got addr=%0d exp 10", wr_addr); else n_pass++;
        req_val = 4'b0000;
        @(posedge clk); #1;
        n_total++; if (wr_en !== 1'b0 || wr_addr !== 5'd10) $display("FAIL sparse_idle got en=%b addr=%0d exp en=0 addr=10", wr_en, wr_addr); else n_pass++;
    endtask

    task automatic test_init_collision();
        // ptr is 1 here
        req_val = 4'b0011;
        init_req = 1'b1; #1;
        n_total++; if (req_rdy !== 4'b0000) $display("FAIL coll_rdy got %b exp 0000", req_rdy); else n_pass++;
        @(posedge clk); #1;
        init_req = 1'b0;
        n_total++; if (wr_en !== 1'b0) $display("FAIL coll_no_write got en=%b exp 0", wr_en); else n_pass++;
        n_total++; if (init_done !== 1'b0) $display("FAIL coll_init_done got %b exp 0", init_done); else n_pass++;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            n_total++;
            if (wr_en !== 1'b1 || wr_addr !== 5'(k) || wr_data !== 32'h0 || init_done !== (k == 31))
                $display("FAIL coll_sweep k=%0d got en=%b addr=%0d data=%h done=%b exp en=1 addr=%0d data=0 done=%b", k, wr_en, wr_addr, wr_data, init_done, k, (k == 31));
            else n_pass++;
            n_total++;
            if (req_rdy !== ((k == 31) ? 4'b0010 : 4'b0000))
                $display("FAIL coll_sweep_rdy k=%0d got %b exp %b", k, req_rdy, ((k == 31) ? 4'b0010 : 4'b0000));
            else n_pass++;
        end
        @(posedge clk); #1;
        req_val = 4'b0000;
        n_total++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd11 || wr_data !== 32'hA1)
            $display("FAIL coll_first_grant got en=%b addr=%0d data=%h exp en=1 addr=11 data=a1", wr_en, wr_addr, wr_data);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        req_val = 4'b0100; #1;
        n_total++; if (req_rdy !== 4'b0100) $display("FAIL ar_rdy got %b exp 0100", req_rdy); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (wr_en !== 1'b1 || wr_addr !== 5'd12) $display("FAIL ar_stream got en=%b addr=%0d exp en=1 addr=12", wr_en, wr_addr); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (wr_en !== 1'b0) $display("FAIL ar_wr_en_async got %b exp 0", wr_en); else n_pass++;
        n_total++; if (wr_addr !== 5'd0 || wr_data !== 32'h0) $display("FAIL ar_outputs got addr=%0d data=%h exp 0 0", wr_addr, wr_data); else n_pass++;
        n_total++; if (init_done !== 1'b0 || req_rdy !== 4'b0000) $display("FAIL ar_done_rdy got done=%b rdy=%b exp 0 0000", init_done, req_rdy); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            n_total++;
            if (wr_en !== 1'b1 || wr_addr !== 5'(k) || req_rdy !== ((k == 31) ? 4'b0100 : 4'b0000))
                $display("FAIL ar_resweep k=%0d got en=%b addr=%0d rdy=%b exp en=1 addr=%0d rdy=%b", k, wr_en, wr_addr, req_rdy, k, ((k == 31) ? 4'b0100 : 4'b0000));
            else n_pass++;
        end
        req_val = 4'b0000;
    endtask

    task automatic test_full_range();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++; if (s_wr_en !== 1'b0 || s_init_done !== 1'b0) $display("FAIL fr_reset got en=%b done=%b exp 0 0", s_wr_en, s_init_done); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_total++;
            if (s_wr_en !== 1'b1 || s_wr_addr !== 3'(k) || s_wr_data !== 16'h5A5A || s_init_done !== (k == 7))
                $display("FAIL fr_sweep k=%0d got en=%b addr=%0d data=%h done=%b exp en=1 addr=%0d data=5a5a done=%b", k, s_wr_en, s_wr_addr, s_wr_data, s_init_done, k, (k == 7));
            else n_pass++;
        end
        @(posedge clk); #1;
        n_total++;
        if (s_wr_en !== 1'b0 || s_wr_addr !== 3'd7 || s_init_done !== 1'b1)
            $display("FAIL fr_no_wrap got en=%b addr=%0d done=%b exp en=0 addr=7 done=1", s_wr_en, s_wr_addr, s_init_done);
        else n_pass++;
        s_req_addr[6 +: 3]   = 3'd7;
        s_req_data[32 +: 16] = 16'hBEEF;
        s_req_val = 4'b0100; #1;
        n_total++; if (s_req_rdy !== 4'b0100) $display("FAIL fr_grant got %b exp 0100", s_req_rdy); else n_pass++;
        @(posedge clk); #1;
        s_req_val = 4'b0000;
        n_total++;
        if (s_wr_en !== 1'b1 || s_wr_addr !== 3'd7 || s_wr_data !== 16'hBEEF)
            $display("FAIL fr_write7 got en=%b addr=%0d data=%h exp en=1 addr=7 data=beef", s_wr_en, s_wr_addr, s_wr_data);
        else n_pass++;
        @(posedge clk); #1;
        n_total++; if (s_wr_en !== 1'b0 || s_init_done !== 1'b1) $display("FAIL fr_idle got en=%b done=%b exp 0 1", s_wr_en, s_init_done); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        init_req = 1'b0;
        req_val = 4'b0000;
        s_init_req = 1'b0;
        s_req_val = 4'b0000;
        s_req_addr = '0;
        s_req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*5 +: 5]   = 5'(10 + i);
            req_data[i*32 +: 32] = 32'(32'hA0 + i);
        end
        test_reset();
        test_round_robin();
        test_sparse();
        test_init_collision();
        test_async_reset();
        test_full_range();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_wr_ctrl.md
# regfile_wr_ctrl

Write-port controller for the multi-ported register file. It shares the file's single write port (address, data, write-enable) between four requesters using a round-robin valid/ready arbiter. After reset, and on request, it sequences an initialization sweep that writes a fixed value to every entry from lo to hi. It sits directly in front of the register file's write port; the read ports are untouched.

## Interface
Parameters:
- addr_width, 5, width of every address
- data_width, 32, width of every data word
- lo, 0, lowest valid entry index
- hi, 31, highest valid entry index (hi >= lo)
- init_val, 0, data_width-wide value written during the init sweep

Ports:
- CLK  in  1  clock; all state changes on posedge
- RST  in  1  reset, **asynchronous, active-high**
- INIT_REQ  in  1  single-cycle pulse that restarts the init sweep
- REQ_VAL  in  4  per-requester write valid
- REQ_ADDR  in  4*addr_width  packed addresses; requester i occupies bits [i*addr_width +: addr_width]
- REQ_DATA  in  4*data_width  packed data; requester i occupies bits [i*data_width +: data_width]
- REQ_RDY  out  4  one-hot grant; combinational from REQ_VAL and state
- WR_EN  out  1  registered write enable to the register file
- WR_ADDR  out  addr_width  registered write address
- WR_DATA  out  data_width  registered write data
- INIT_DONE  out  1  high while in RUN

## Operation
- FSM states: INIT and RUN.
- On reset: state INIT, cnt=lo, ptr=0. WR_EN=0, WR_ADDR=0, WR_DATA=0, INIT_DONE=0, REQ_RDY=0.
- INIT behaviour:
  - REQ_RDY=0 and REQ_VAL is ignored.
  - Each cycle registers WR_EN=1, WR_ADDR=cnt, WR_DATA=init_val, then cnt=cnt+1.
  - When cnt==hi, the state moves to RUN and INIT_DONE is registered to 1.
- RUN, arbitration:
  - Search for a valid requester starting at ptr, wrapping 3→0.
  - The first valid requester g gets REQ_RDY[g]=1.
  - A transfer occurs when REQ_VAL[g] and REQ_RDY[g] are both high.
- RUN, on a transfer:
  - Next cycle WR_EN=1, WR_ADDR=REQ_ADDR[g], WR_DATA=REQ_DATA[g].
  - ptr=(g+1) mod 4.
- RUN, no valid requester: WR_EN=0 next cycle; WR_ADDR, WR_DATA and ptr hold.
- INIT_REQ in RUN:
  - Takes priority: REQ_RDY=0 in that cycle and no transfer occurs.
  - Next state is INIT with cnt=lo; INIT_DONE falls to 0 in the next cycle.
  - ptr is preserved.
- INIT_REQ during INIT: restarts the sweep with cnt=lo.
- Requesters hold REQ_VAL, REQ_ADDR and REQ_DATA stable until the transfer.
- Address range check: any transfer with an address outside [lo,hi] is still forwarded. Simulation only (translate_off) displays a warning.
- Counter width: cnt is addr_width bits. The sweep terminates by comparing cnt==hi, never by overflow, so it is safe for hi = 2^addr_width−1.

## Timing
- Request-to-write latency: exactly 1 cycle from the transfer edge to WR_EN at the register file. Data is visible to read ports 2 cycles after the transfer cycle.
- Throughput: one write per cycle sustained. A single requester held valid is granted every cycle.
- Init sweep length: exactly hi−lo+1 consecutive WR_EN cycles.
  - After RST deasserts, the first sweep WR_EN is seen after the first posedge.
  - INIT_DONE rises together with the WR_EN for address hi.
  - REQ_RDY can first be 1 in that same cycle.
- Reset mid-sweep or mid-transfer: all outputs return immediately (asynchronously) to their reset values, and the sweep restarts from lo.
- No combinational path from REQ_ADDR or REQ_DATA to any output. REQ_RDY depends only on REQ_VAL, ptr, state and INIT_REQ.

## Structure
- Shared package regfile_ctrl_pkg holds:
  - state encoding localparams ST_INIT=1'b0, ST_RUN=1'b1
  - N_REQ=4
- Sub-module rr_arb4:
  - inputs: REQ[3:0], PTR[1:0], EN
  - outputs: one-hot GNT[3:0], encoded GIDX[1:0]
  - purely combinational
- The top level holds the FSM, cnt, ptr and the output registers.

## Test plan
- **Reset and init sweep.** Defaults, RST pulse, REQ_VAL=4'b1111 held throughout.
  - WR_EN high for 32 cycles with WR_ADDR 0..31 and WR_DATA=0.
  - REQ_RDY=0 until INIT_DONE=1 on the WR_ADDR=31 cycle.
- **Round-robin fairness.** After init, all four requesters valid continuously.
  - Grants go 0,1,2,3,0,… one per cycle.
  - WR_ADDR follows the granted requester one cycle later.
- **Sparse requests.** ptr=2 with only requesters 0 and 1 valid.
  - Grant goes to 0, then 1.
  - Requester 3 going valid next is granted before 0.
- **INIT_REQ collision.** INIT_REQ pulses in a cycle with REQ_VAL[1]=1.
  - No REQ_RDY that cycle and no request write issued.
  - A 32-cycle sweep follows, then requester 1 is granted first.
- **Async reset mid-stream.** RST asserted between clock edges during streaming writes.
  - WR_EN drops to 0 immediately, without waiting for CLK.
  - After release the sweep restarts at address 0.
- **Full address range.** addr_width=3, lo=0, hi=7.
  - Sweep writes 0..7, exits to RUN and does not wrap.
  - A request to address 7 is then written with the correct data.
